// File: rtl/lock_key_loader.sv
// Serial key loader feeding the 7 key inputs (X_1..X_3, p1..p4) of the locked c432 netlist.
// Define LOCK_KEY_LOADER_PARITY_EN to append an even-parity bit to each serial key load.
module lock_key_loader #(
  parameter int KEY_W = 7,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  output logic             busy,
  output logic [KEY_W-1:0] key_out,
  output logic             key_loaded,
  output logic             key_err
);

`ifdef LOCK_KEY_LOADER_PARITY_EN
  localparam int SH_W = KEY_W + 1;
`else
  localparam int SH_W = KEY_W;
`endif

  // The counter saturates on the final beat rather than stepping past the last index.
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(SH_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [SH_W-1:0]  r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_key_out;
  logic             r_key_loaded;
  logic             w_beat;
  logic             w_pass;

  assign sdi_ready  = (r_state == S_SHIFT);
  assign busy       = (r_state == S_SHIFT) || (r_state == S_CHECK);
  assign w_beat     = sdi_valid && sdi_ready;
  assign key_out    = r_key_out;
  assign key_loaded = r_key_loaded;

`ifdef LOCK_KEY_LOADER_PARITY_EN
  logic r_key_err;

  // Even parity over key plus parity bit: the XOR of the whole shadow must be zero.
  assign w_pass  = ~(^r_shadow);
  assign key_err = r_key_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_err <= 1'b0;
    end else if (clear) begin
      r_key_err <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_key_err <= 1'b0;
    end else if (r_state == S_CHECK) begin
      r_key_err <= ~w_pass;
    end
  end
`else
  assign w_pass  = 1'b1;
  assign key_err = 1'b0;
`endif

  // NOTE: all state here is sequential, so every assignment is non-blocking; blocking
  // assignments would let later statements see half-updated state within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shadow     <= '0;
      r_cnt        <= '0;
      r_key_out    <= '0;
      r_key_loaded <= 1'b0;
    end else if (clear) begin
      r_state      <= S_IDLE;
      r_shadow     <= '0;
      r_cnt        <= '0;
      r_key_out    <= '0;
      r_key_loaded <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_SHIFT;
            r_shadow <= '0;
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          if (w_beat) begin
            for (int i = 0; i < SH_W; i++) begin
              if (r_cnt == CNT_W'(i)) r_shadow[i] <= sdi;
            end
            if (r_cnt == LAST_BEAT) begin
              r_state <= S_CHECK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_CHECK: begin
          // The committed key changes only here, so the netlist never sees a partial key.
          if (w_pass) begin
            r_key_out    <= r_shadow[KEY_W-1:0];
            r_key_loaded <= 1'b1;
          end else begin
            r_key_out    <= '0;
            r_key_loaded <= 1'b0;
          end
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// Bench for lock_key_loader: table vectors, hand-written corner sequences and random loads
// against a bit-list reference model.
module tb_lock_key_loader;

  localparam int KEY_W = 7;
`ifdef LOCK_KEY_LOADER_PARITY_EN
  localparam int NB = KEY_W + 1;
`else
  localparam int NB = KEY_W;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             clear;
  logic             sdi;
  logic             sdi_valid;
  logic             sdi_ready;
  logic             busy;
  logic [KEY_W-1:0] key_out;
  logic             key_loaded;
  logic             key_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference view of what the netlist should currently see.
  logic [KEY_W-1:0] m_key    = '0;
  logic             m_loaded = 1'b0;
  logic             m_err    = 1'b0;

  typedef struct {
    logic [KEY_W-1:0] key;
    logic             pb;
    int               mode;      // 0 back-to-back, 1 alternating valid, 2 random gaps
    int               start_at;  // beat index at which a stray start is pulsed (-1 none)
    logic [KEY_W-1:0] exp_key;
    logic             exp_loaded;
    logic             exp_err;
  } vec_t;

  vec_t vecs[$];

  lock_key_loader #(.KEY_W(KEY_W), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .sdi        (sdi),
    .sdi_valid  (sdi_valid),
    .sdi_ready  (sdi_ready),
    .busy       (busy),
    .key_out    (key_out),
    .key_loaded (key_loaded),
    .key_err    (key_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_pass(input logic [KEY_W-1:0] key, input logic pb);
`ifdef LOCK_KEY_LOADER_PARITY_EN
    int ones = 0;
    for (int i = 0; i < KEY_W; i++) ones += int'(key[i]);
    return ((ones + int'(pb)) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic shift_bits(input logic [NB-1:0] bits, input int first, input int last,
                            input int mode, input int start_at, input logic [KEY_W-1:0] prior);
    int gap;
    for (int i = first; i <= last; i++) begin
      gap = (mode == 2) ? int'($urandom_range(0, 2)) : ((mode == 1 && i > 0) ? 1 : 0);
      repeat (gap) begin
        check("ready_idle_gap", sdi_ready, 1);
        check("key_held_shift", key_out, prior);
        tick();
      end
      if (i == start_at) start = 1'b1;
      sdi       = bits[i];
      sdi_valid = 1'b1;
      tick();
      sdi_valid = 1'b0;
      sdi       = 1'b0;
      start     = 1'b0;
    end
  endtask

  // Complete load; returns the outputs seen one cycle after the last beat.
  task automatic load_key(input logic [KEY_W-1:0] key, input logic pb, input int mode,
                          input int start_at, output logic [KEY_W-1:0] o_key,
                          output logic o_loaded, output logic o_err);
    logic [NB-1:0] bits;
    logic [KEY_W-1:0] prior;
    bits[KEY_W-1:0] = key;
`ifdef LOCK_KEY_LOADER_PARITY_EN
    bits[NB-1] = pb;
`endif
    prior = m_key;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_in_shift", busy, 1);
    check("err_cleared_on_start", key_err, 0);
    shift_bits(bits, 0, NB - 1, mode, start_at, prior);
    check("ready_in_check", sdi_ready, 0);
    check("busy_in_check", busy, 1);
    check("key_not_yet_committed", key_out, prior);
    tick();
    o_key    = key_out;
    o_loaded = key_loaded;
    o_err    = key_err;
    check("busy_in_done", busy, 0);
    tick();
    check("ready_back_in_idle", sdi_ready, 0);
  endtask

  logic [KEY_W-1:0] a_key;
  logic             a_loaded;
  logic             a_err;

  initial begin
    logic [KEY_W-1:0] rk;
    logic             rpb;
    logic             pass;

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; sdi = 1'b0; sdi_valid = 1'b0;
    #12;
    check("reset_key_out", key_out, 0);
    check("reset_loaded", key_loaded, 0);
    check("reset_err", key_err, 0);
    check("reset_ready", sdi_ready, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    vecs.push_back('{7'h56, 1'b0, 0, -1, 7'h56, 1'b1, 1'b0});
    vecs.push_back('{7'h56, 1'b0, 1, -1, 7'h56, 1'b1, 1'b0});
`ifdef LOCK_KEY_LOADER_PARITY_EN
    vecs.push_back('{7'h56, 1'b1, 0, -1, 7'h00, 1'b0, 1'b1});
`endif
    vecs.push_back('{7'h2B, 1'b0, 0, 3, 7'h2B, 1'b1, 1'b0});
    vecs.push_back('{7'h7F, 1'b1, 1, -1, 7'h7F, 1'b1, 1'b0});
    vecs.push_back('{7'h00, 1'b0, 2, -1, 7'h00, 1'b1, 1'b0});

    foreach (vecs[v]) begin
      load_key(vecs[v].key, vecs[v].pb, vecs[v].mode, vecs[v].start_at, a_key, a_loaded, a_err);
      check("vec_key_out", a_key, vecs[v].exp_key);
      check("vec_key_loaded", a_loaded, vecs[v].exp_loaded);
      check("vec_key_err", a_err, vecs[v].exp_err);
      m_key = vecs[v].exp_key; m_loaded = vecs[v].exp_loaded; m_err = vecs[v].exp_err;
    end

    // Clear abandons a load; the beat coincident with clear is dropped.
    load_key(7'h56, 1'b0, 0, -1, a_key, a_loaded, a_err);
    check("preclear_key", a_key, 7'h56);
    m_key = 7'h56; m_loaded = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    shift_bits(NB'(7'h2B), 0, 2, 0, -1, m_key);
    check("key_held_partial", key_out, 7'h56);
    clear = 1'b1; sdi = 1'b1; sdi_valid = 1'b1;
    tick();
    clear = 1'b0; sdi_valid = 1'b0;
    m_key = '0; m_loaded = 1'b0; m_err = 1'b0;
    check("clear_key_out", key_out, 0);
    check("clear_loaded", key_loaded, 0);
    check("clear_err", key_err, 0);
    check("clear_busy", busy, 0);
    for (int p = 0; p < 4; p++) begin
      sdi_valid = 1'b1;
      check("ready_after_clear", sdi_ready, 0);
      tick();
      sdi_valid = 1'b0;
      check("busy_after_clear", busy, 0);
    end
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    check("start_clear_busy", busy, 0);
    check("start_clear_ready", sdi_ready, 0);
    load_key(7'h2B, 1'b0, 0, -1, a_key, a_loaded, a_err);
    check("postclear_key", a_key, 7'h2B);
    check("postclear_loaded", a_loaded, 1);
    m_key = 7'h2B; m_loaded = 1'b1;

    // Asynchronous reset mid-shift must blank the key without a clock edge.
    load_key(7'h56, 1'b0, 0, -1, a_key, a_loaded, a_err);
    m_key = 7'h56;
    start = 1'b1; tick(); start = 1'b0;
    shift_bits(NB'(7'h11), 0, 1, 0, -1, m_key);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_key_out", key_out, 0);
    check("async_rst_loaded", key_loaded, 0);
    check("async_rst_busy", busy, 0);
    m_key = '0; m_loaded = 1'b0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    load_key(7'h2B, 1'b0, 0, -1, a_key, a_loaded, a_err);
    check("after_rst_key", a_key, 7'h2B);
    m_key = 7'h2B; m_loaded = 1'b1;

    // Random loads against the model.
    for (int r = 0; r < 40; r++) begin
      rk  = KEY_W'($urandom);
      rpb = ^rk;
`ifdef LOCK_KEY_LOADER_PARITY_EN
      if ($urandom_range(0, 3) == 0) rpb = ~rpb;
`endif
      pass = model_pass(rk, rpb);
      load_key(rk, rpb, 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1,
               a_key, a_loaded, a_err);
      m_key    = pass ? rk : '0;
      m_loaded = pass;
`ifdef LOCK_KEY_LOADER_PARITY_EN
      m_err    = ~pass;
`else
      m_err    = 1'b0;
`endif
      check("rand_key_out", a_key, m_key);
      check("rand_loaded", a_loaded, m_loaded);
      check("rand_err", a_err, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lock_key_loader.md
Name: lock_key_loader

Overview:
- Serial key loader that sits directly upstream of the locked c432 netlist and drives its 7 key inputs: XOR key gates X_1..X_3 and mux key inputs p1..p4.
- Accepts the key one bit per beat from the secure key store over a valid/ready handshake and assembles it in a shadow register.
- Commits the assembled key atomically to the key outputs. Until a commit, the locked netlist sees the all-zero key.

Parameters:
- KEY_W, 7, key width in bits. Bit map: [0]=X_1, [1]=X_2, [2]=X_3, [3]=p1, [4]=p2, [5]=p3, [6]=p4.
- CNT_W, 3, width of the bit counter. Must satisfy 2^CNT_W >= KEY_W+1.

Ports:
- clk  input  1  single clock for the whole block.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load.
- clear  input  1  synchronous pulse that zeroes the committed key and returns to IDLE.
- sdi  input  1  serial key bit.
- sdi_valid  input  1  sdi carries a valid bit this cycle.
- sdi_ready  output  1  block accepts sdi this cycle.
- busy  output  1  a load is in progress.
- key_out  output  KEY_W  committed key bits, wired to X_1..X_3 and p1..p4.
- key_loaded  output  1  key_out holds a committed key.
- key_err  output  1  the last load failed its check.

Behaviour:
- Reset (rst_n=0, asynchronous) forces: state=IDLE, shadow=0, bit counter=0, key_out=0, key_loaded=0, key_err=0, sdi_ready=0, busy=0.
- States: IDLE, SHIFT, CHECK, DONE.
- IDLE:
  - start=1 -> SHIFT. Clears shadow, counter and key_err.
  - key_out and key_loaded are unchanged, so a previously loaded key stays active.
- SHIFT:
  - sdi_ready=1 and busy=1.
  - A beat occurs when sdi_valid && sdi_ready. On a beat: shadow[cnt] <= sdi and cnt <= cnt+1. Bits arrive LSB first.
  - No beat -> hold, with no timeout.
  - The beat that takes cnt to KEY_W (or KEY_W+1 with parity) moves the FSM to CHECK in the next cycle.
- CHECK:
  - Lasts exactly one cycle. sdi_ready=0, busy=1.
  - Pass -> key_out <= shadow, key_loaded <= 1, go to DONE.
  - Fail -> key_out <= 0, key_loaded <= 0, key_err <= 1, go to DONE.
  - Without parity, the check always passes.
- DONE:
  - Lasts one cycle with busy=0, then returns to IDLE.
- Latency: key_out updates on the clock edge that leaves CHECK, i.e. one cycle after the last beat is accepted.
- start while not in IDLE: ignored.
- clear:
  - Highest priority after reset, in any state.
  - Sets key_out=0, key_loaded=0, key_err=0, shadow=0, cnt=0, state=IDLE.
  - An in-flight load is abandoned. A beat in the same cycle as clear is discarded.
- Simultaneous start and clear: clear wins and the FSM stays in IDLE.
- key_out never shows a partial key. It changes only in CHECK, on clear, or on reset.
- Reset asserted mid-SHIFT: all partial state is lost. The bench must see key_out=0 immediately; no wait for a clock edge.
- The counter never wraps: SHIFT exits before cnt would exceed KEY_W+1.

Optional Feature:
- Macro: LOCK_KEY_LOADER_PARITY_EN.
- Defined:
  - One extra serial bit follows the key bits, for KEY_W+1 beats in total.
  - CHECK passes iff XOR(shadow[KEY_W-1:0]) == parity bit, i.e. even parity over key plus parity bit.
  - The parity bit is not driven on key_out.
- Undefined:
  - Exactly KEY_W beats.
  - No parity register.
  - key_err is tied to 0.

Test Plan:
- Reset, then start, then 7 back-to-back beats with bits 0,1,1,0,1,0,1 (key_out target 7'b1010110) -> key_out=7'h56 and key_loaded=1 one cycle after the 7th beat; sdi_ready=0 in CHECK.
- Same key with sdi_valid toggling 1,0,1,0… -> identical final key_out=7'h56. Only beats with sdi_valid=1 advance cnt. key_out stays at its prior value during SHIFT.
- Load 7'h56, then start and 3 beats of a second key, then clear -> key_out=0, key_loaded=0, state IDLE. A further 4 sdi_valid pulses produce no beat (sdi_ready=0).
- Load 7'h56, then assert rst_n=0 mid-cycle during SHIFT of a new key -> key_out=0 asynchronously. After release, start plus 7 beats of 7'h2B -> key_out=7'h2B.
- start pulsed at beat 3 of SHIFT -> ignored; the load completes normally after 7 beats.
- With LOCK_KEY_LOADER_PARITY_EN:
  - Key 7'h56 (four ones) with parity bit 0 -> key_out=7'h56, key_err=0.
  - Same key with parity bit 1 -> key_out=0, key_loaded=0, key_err=1.
